mux5_rr_arbiter: RTL and testbench
==================================

Name: mux5_rr_arbiter

Overview:
- Round-robin arbiter and select sequencer for the shared 3-bit 5-to-1 mux.
- Five requesters contend for the mux output. The arbiter grants one requester at a time and drives the mux select S with that requester's index.
- Each grant is time-limited, so no requester can starve the others.
- It sits in front of the mux and is the only driver of its S input.

Parameters:
- HOLD_MAX, default 4: maximum consecutive cycles one grant is held. Legal range is 1..7.
- CNT_W, default 3: width of the hold counter. It must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset, sampled on the CLK rising edge.
- REQ  in  5  request vector; REQ[k] is requester k (k = 0..4).
- GNT  out  5  registered grant vector, one-hot or all-zero.
- S  out  3  registered mux select. It carries the granted index 3'b000..3'b100, and 3'b000 when idle.
- VALID  out  1  registered; high when GNT is non-zero, i.e. the mux output is owned.
- LOCK  in  1  present only when MUX5_ARB_LOCK_EN is defined (see Optional Feature).

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset (RST=1 at an edge):
  - GNT=5'b00000, S=3'b000, VALID=0.
  - state=IDLE, priority pointer PTR=0, hold counter CNT=0.
  - Reset overrides everything; an in-progress grant is dropped at that edge with no completion.
- State IDLE (VALID=0, GNT=0):
  - Trigger: any REQ bit is set at an edge.
  - Winner: the first set bit scanning PTR, PTR+1, ... modulo 5.
  - At that same edge: GNT=onehot(winner), S=winner, VALID=1, CNT=1, state→BUSY.
  - Latency: REQ sampled high at edge n gives GNT visible after edge n. This is one registered stage and there is no combinational REQ→GNT path.
- State BUSY (current grant g):
  - Continue: REQ[g]=1 and CNT<HOLD_MAX. Then CNT=CNT+1 and the outputs hold.
  - Release: REQ[g]=0 or CNT==HOLD_MAX. On release, PTR=(g+1) mod 5, so 4 wraps to 0.
  - Release handoff without a bubble: if any REQ bit is set, re-arbitrate at the same edge from the new PTR. The new winner gets GNT/S at that edge with CNT=1.
  - The new winner may be g itself, but only if no other requester is asserting.
  - Release with no REQ bit set: state→IDLE, GNT=0, S=3'b000, VALID=0.
- REQ drop timing: GNT[g] remains high during the cycle in which REQ[g] is low. It clears at the following edge.
- Invariants:
  - S is never 3'b101..3'b111.
  - GNT has at most one bit set.
  - VALID == |GNT.
  - When VALID=1, S equals the index of the set GNT bit.
- HOLD_MAX=1: the grant rotates every cycle among active requesters.
- All 5 requesting continuously: grants go in order 0,1,2,3,4,0,... with each held for exactly HOLD_MAX cycles.
- CNT saturates at HOLD_MAX and never wraps.

Optional Feature:
- Macro: MUX5_ARB_LOCK_EN.
- When defined:
  - The LOCK input port exists.
  - In BUSY, if LOCK=1 and REQ[g]=1, the hold limit is ignored: the grant continues and CNT stays saturated at HOLD_MAX.
  - When LOCK returns to 0 with CNT==HOLD_MAX, release occurs at the next edge.
  - LOCK has no effect in IDLE and no effect once REQ[g]=0.
- When not defined: the LOCK port is absent, and the hold limit always applies.

Test Plan:
- Reset release: RST=1 for 2 cycles with REQ=5'b11111, then RST=0 → GNT=0, S=0, VALID=0 while in reset. First edge after release gives GNT=5'b00001, S=3'b000, VALID=1.
- Single requester: REQ=5'b00100 steady, HOLD_MAX=4 → GNT=5'b00100, S=3'b010 held 4 cycles. Then a same-edge re-grant to requester 2 (no others), with VALID never dropping.
- Full contention: REQ=5'b11111 for 22 cycles → S sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,4,4,4,4,0,0; GNT stays one-hot throughout.
- Early drop and wrap:
  - Grant on requester 4 at CNT=2, then drop REQ[4] with REQ=5'b00011 → GNT[4] stays high one more cycle.
  - Next grant is requester 0 (PTR wrapped), S=3'b000, CNT=1.
- Idle return: sole requester 1 drops REQ → at the next edge VALID=0, GNT=0, S=3'b000. REQ=5'b01000 two cycles later → grant to 3.
- Lock (MUX5_ARB_LOCK_EN): REQ=5'b00011, LOCK=1 for 10 cycles → requester 0 holds GNT for all 10 cycles. After LOCK=0, release at the next edge and grant moves to 1.

Source files
------------

// File: rtl/mux5_rr_arbiter.sv
// Round-robin arbiter that owns the select line of a shared 5-to-1 mux, with time-limited grants.
// Optional MUX5_ARB_LOCK_EN adds a LOCK input that extends the current grant past the hold limit.
module mux5_rr_arbiter #(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] REQ,
`ifdef MUX5_ARB_LOCK_EN
  input  logic       LOCK,
`endif
  output logic [4:0] GNT,
  output logic [2:0] S,
  output logic       VALID
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  state_t           state, state_nxt;
  logic [2:0]       ptr, ptr_nxt, rel_ptr;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [4:0]       gnt_nxt;
  logic [2:0]       s_nxt;
  logic             valid_nxt;
  logic [3:0]       win_idle, win_rel;
  logic             hold_ok, lock_hold;

  // Returns {found, index} of the first set request scanning start, start+1, ... mod 5.
  function automatic logic [3:0] pick(input logic [4:0] req, input logic [2:0] start);
    logic [3:0] r;
    int         idx;
    r = 4'b0000;
    for (int k = 4; k >= 0; k--) begin
      idx = (int'(start) + k) % 5;
      if (req[idx]) r = {1'b1, 3'(idx)};
    end
    return r;
  endfunction

  function automatic logic [4:0] onehot(input logic [2:0] idx);
    return 5'b00001 << idx;
  endfunction

`ifdef MUX5_ARB_LOCK_EN
  assign lock_hold = LOCK;
`else
  assign lock_hold = 1'b0;
`endif

  assign hold_ok  = (cnt < HOLD_LIM);
  assign rel_ptr  = (S == 3'd4) ? 3'd0 : S + 3'd1;
  assign win_idle = pick(REQ, ptr);
  assign win_rel  = pick(REQ, rel_ptr);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    gnt_nxt   = GNT;
    s_nxt     = S;
    valid_nxt = VALID;
    case (state)
      IDLE: begin
        if (win_idle[3]) begin
          state_nxt = BUSY;
          gnt_nxt   = onehot(win_idle[2:0]);
          s_nxt     = win_idle[2:0];
          valid_nxt = 1'b1;
          cnt_nxt   = CNT_W'(1);
        end
      end
      BUSY: begin
        if (REQ[S] && (hold_ok || lock_hold)) begin
          // Under LOCK the counter parks at the limit instead of wrapping.
          if (hold_ok) cnt_nxt = cnt + CNT_W'(1);
        end else begin
          ptr_nxt = rel_ptr;
          if (win_rel[3]) begin
            gnt_nxt   = onehot(win_rel[2:0]);
            s_nxt     = win_rel[2:0];
            valid_nxt = 1'b1;
            cnt_nxt   = CNT_W'(1);
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = 5'b00000;
            s_nxt     = 3'b000;
            valid_nxt = 1'b0;
            cnt_nxt   = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= 3'd0;
      cnt   <= '0;
      GNT   <= 5'b00000;
      S     <= 3'b000;
      VALID <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      GNT   <= gnt_nxt;
      S     <= s_nxt;
      VALID <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_mux5_rr_arbiter.sv
// Bench for mux5_rr_arbiter: directed vector table plus random traffic against a queue-free reference model.
module tb_mux5_rr_arbiter;

  localparam int HOLD = 4;
`ifdef MUX5_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       LOCK;
  logic [4:0] REQ;
  logic [4:0] GNT;
  logic [2:0] S;
  logic       VALID;

  always #5 CLK = ~CLK;

  mux5_rr_arbiter #(.HOLD_MAX(HOLD), .CNT_W(3)) dut (
    .CLK(CLK),
    .RST(RST),
    .REQ(REQ),
`ifdef MUX5_ARB_LOCK_EN
    .LOCK(LOCK),
`endif
    .GNT(GNT),
    .S(S),
    .VALID(VALID)
  );

  typedef struct {
    logic       rst;
    logic [4:0] req;
    logic       lock;
    logic [4:0] gnt;
    logic [2:0] s;
    logic       valid;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: current owner (-1 = none), cycles held, rotation start.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;

  function automatic int scan(input logic [4:0] r, input int p);
    for (int k = 0; k < 5; k++)
      if (r[(p + k) % 5]) return (p + k) % 5;
    return -1;
  endfunction

  task automatic model_step();
    bit lk;
    lk = LOCK_EN && (LOCK === 1'b1);
    if (RST) begin
      m_owner = -1; m_held = 0; m_ptr = 0;
    end else if (m_owner < 0) begin
      m_owner = scan(REQ, m_ptr);
      m_held  = (m_owner >= 0) ? 1 : 0;
    end else if (REQ[m_owner] && (m_held < HOLD || lk)) begin
      if (m_held < HOLD) m_held++;
    end else begin
      m_ptr   = (m_owner + 1) % 5;
      m_owner = scan(REQ, m_ptr);
      m_held  = (m_owner >= 0) ? 1 : 0;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic [4:0] req, input logic lk);
    RST = rst; REQ = req; LOCK = lk;
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [7:0] eg;
    eg = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
    chk({tag, "_gnt"}, {3'b0, GNT}, eg);
    chk({tag, "_s"}, {5'b0, S}, (m_owner >= 0) ? 8'(m_owner) : 8'd0);
    chk({tag, "_valid"}, {7'b0, VALID}, (m_owner >= 0) ? 8'd1 : 8'd0);
    chk({tag, "_onehot"}, {7'b0, $onehot0(GNT)}, 8'd1);
    chk({tag, "_s_range"}, {7'b0, (S <= 3'd4)}, 8'd1);
  endtask

  task automatic add(input logic rst, input logic [4:0] req, input logic lk,
                     input logic [4:0] g, input logic [2:0] s, input logic v);
    vec_t e;
    e.rst = rst; e.req = req; e.lock = lk; e.gnt = g; e.s = s; e.valid = v;
    tbl.push_back(e);
  endtask

  initial begin
    logic [4:0] rq;
    logic [2:0] sx;
    RST = 1'b1; REQ = 5'b00000; LOCK = 1'b0;

    // Reset with everyone requesting, then 22 cycles of full contention.
    add(1'b1, 5'b11111, 1'b0, 5'b00000, 3'd0, 1'b0);
    add(1'b1, 5'b11111, 1'b0, 5'b00000, 3'd0, 1'b0);
    for (int i = 0; i < 22; i++) begin
      sx = 3'((i / HOLD) % 5);
      add(1'b0, 5'b11111, 1'b0, 5'b00001 << sx, sx, 1'b1);
    end
    // Sole requester 2: held, then re-granted to itself with no bubble.
    add(1'b1, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0);
    for (int i = 0; i < 9; i++) add(1'b0, 5'b00100, 1'b0, 5'b00100, 3'd2, 1'b1);
    // Early drop on requester 4, pointer wraps to 0, then hold limit hands to 1.
    add(1'b1, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0);
    add(1'b0, 5'b10000, 1'b0, 5'b10000, 3'd4, 1'b1);
    add(1'b0, 5'b10000, 1'b0, 5'b10000, 3'd4, 1'b1);
    for (int i = 0; i < 4; i++) add(1'b0, 5'b00011, 1'b0, 5'b00001, 3'd0, 1'b1);
    add(1'b0, 5'b00011, 1'b0, 5'b00010, 3'd1, 1'b1);
    // Return to idle and a later fresh grant.
    add(1'b1, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0);
    add(1'b0, 5'b00010, 1'b0, 5'b00010, 3'd1, 1'b1);
    add(1'b0, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0);
    add(1'b0, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0);
    add(1'b0, 5'b01000, 1'b0, 5'b01000, 3'd3, 1'b1);
    // Reset drops a live grant immediately.
    add(1'b1, 5'b01000, 1'b0, 5'b00000, 3'd0, 1'b0);
`ifdef MUX5_ARB_LOCK_EN
    for (int i = 0; i < 10; i++) add(1'b0, 5'b00011, 1'b1, 5'b00001, 3'd0, 1'b1);
    add(1'b0, 5'b00011, 1'b0, 5'b00010, 3'd1, 1'b1);
`endif

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].lock);
      chk($sformatf("vec%0d_gnt", i), {3'b0, GNT}, {3'b0, tbl[i].gnt});
      chk($sformatf("vec%0d_s", i), {5'b0, S}, {5'b0, tbl[i].s});
      chk($sformatf("vec%0d_valid", i), {7'b0, VALID}, {7'b0, tbl[i].valid});
      check_model($sformatf("vec%0d_model", i));
    end

    // Random traffic with sticky request patterns and occasional resets.
    rq = 5'b00000;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 5'($urandom);
      step(($urandom_range(0, 59) == 0), rq, ($urandom_range(0, 2) == 0));
      check_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
